// File: rtl/sdram_pkg.sv
// Shared types for the SDRAM request queue: command FSM states and the queued request record.
package sdram_pkg;

    localparam int REQ_ADDR_W = 24;
    localparam int REQ_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic                  we;
        logic [REQ_ADDR_W-1:0] adr;
        logic [REQ_DATA_W-1:0] data;
    } req_t;

endpackage

// File: rtl/sdram_req_fifo.sv
// Synchronous FIFO of host requests; pointers wrap naturally, count has one extra bit for "full".
module sdram_req_fifo
    import sdram_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  req_t                     wdata,
    output req_t                     rdata,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    req_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: only slots below the registered count are ever read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/sdram_req_queue.sv
// Host front end for memory_controller: queues requests, issues them one at a time paced by RDY,
// and returns read data. ADDR_W/DATA_W must match the widths of sdram_pkg::req_t.
module sdram_req_queue
    import sdram_pkg::*;
#(
    parameter int ADDR_W = REQ_ADDR_W,
    parameter int DATA_W = REQ_DATA_W,
    parameter int DEPTH  = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic              REQ_WE,
    input  logic [ADDR_W-1:0] REQ_ADR,
    input  logic [DATA_W-1:0] REQ_DATA,
    output logic              RSP_VALID,
    output logic [DATA_W-1:0] RSP_DATA,
    input  logic              RDY,
    input  logic [DATA_W-1:0] DOUT,
    output logic              RE_IN,
    output logic              WE_IN,
    output logic [ADDR_W-1:0] ADR_IN,
    output logic [DATA_W-1:0] DIN
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    state_t             state;
    state_t             state_next;
    req_t               cmd;
    req_t               fifo_head;
    req_t               fifo_wdata;
    logic               fifo_pop;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic               rsp_valid_q;
    logic [DATA_W-1:0]  rsp_data_q;

    // Readiness comes from the registered count only, so a pop while full frees the slot next cycle.
    assign REQ_READY  = (fifo_count < FULL_COUNT);
    assign fifo_wdata = '{we: REQ_WE, adr: REQ_ADR, data: REQ_DATA};

    sdram_req_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst   (RST),
        .push  (REQ_VALID && REQ_READY),
        .pop   (fifo_pop),
        .wdata (fifo_wdata),
        .rdata (fifo_head),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        fifo_pop   = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty && RDY) begin
                    state_next = ISSUE;
                    fifo_pop   = 1'b1;
                end
            end
            ISSUE:     state_next = WAIT_BUSY;
            WAIT_BUSY: if (!RDY) state_next = WAIT_DONE;
            WAIT_DONE: if (RDY)  state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // The command register keeps ADR_IN/DIN stable from one issue to the next.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cmd <= '0;
        end else if (fifo_pop) begin
            cmd <= fifo_head;
        end
    end

    // DOUT is valid on the first RDY-high cycle after a read, i.e. as WAIT_DONE exits.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            if (state == WAIT_DONE && RDY && !cmd.we) begin
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= DOUT;
            end
        end
    end

    assign RE_IN     = (state == ISSUE) && !cmd.we;
    assign WE_IN     = (state == ISSUE) && cmd.we;
    assign ADR_IN    = cmd.adr;
    assign DIN       = cmd.data;
    assign RSP_VALID = rsp_valid_q;
    assign RSP_DATA  = rsp_data_q;

endmodule

// File: tb/tb_sdram_req_queue.sv
// Directed bench for sdram_req_queue with a small behavioural model of the controller's RDY/DOUT handshake.
module tb_sdram_req_queue;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        REQ_VALID = 1'b0;
    logic        REQ_READY;
    logic        REQ_WE = 1'b0;
    logic [23:0] REQ_ADR = '0;
    logic [15:0] REQ_DATA = '0;
    logic        RSP_VALID;
    logic [15:0] RSP_DATA;
    logic        RDY = 1'b1;
    logic [15:0] DOUT = '0;
    logic        RE_IN;
    logic        WE_IN;
    logic [23:0] ADR_IN;
    logic [15:0] DIN;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        bit          we;
        logic [23:0] adr;
        logic [15:0] data;
        int          at;
    } strobe_t;

    strobe_t     strobes[$];
    logic [15:0] rsps[$];
    int          viol = 0;
    int          last_cyc = -100;
    int          busy_cnt = 0;
    int          lat = 3;
    bit          hold_rdy = 1'b0;
    bit          rand_lat = 1'b0;
    bit          fixed_dout = 1'b1;
    logic [15:0] dout_val = '0;
    logic [15:0] pend_dout = '0;

    sdram_req_queue #(.ADDR_W(24), .DATA_W(16), .DEPTH(8)) dut (
        .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .REQ_WE(REQ_WE), .REQ_ADR(REQ_ADR), .REQ_DATA(REQ_DATA),
        .RSP_VALID(RSP_VALID), .RSP_DATA(RSP_DATA), .RDY(RDY), .DOUT(DOUT),
        .RE_IN(RE_IN), .WE_IN(WE_IN), .ADR_IN(ADR_IN), .DIN(DIN)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Controller model: drops RDY right after a strobe, raises it again after the latency with DOUT loaded.
    always @(negedge CLK) begin
        if (RST) begin
            busy_cnt = 0;
            RDY      = 1'b1;
            last_cyc = -100;
        end else begin
            if (RE_IN || WE_IN) begin
                if (RE_IN && WE_IN) viol++;
                if (cyc - last_cyc < 4) viol++;
                last_cyc = cyc;
                strobes.push_back('{WE_IN, ADR_IN, DIN, cyc});
                busy_cnt  = rand_lat ? int'($urandom_range(2, 6)) : lat;
                pend_dout = fixed_dout ? dout_val : (16'hC000 | ADR_IN[15:0]);
                RDY       = 1'b0;
            end else if (hold_rdy) begin
                RDY = 1'b0;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) begin
                    RDY  = 1'b1;
                    DOUT = pend_dout;
                end
            end else begin
                RDY = 1'b1;
            end
            if (RSP_VALID) rsps.push_back(RSP_DATA);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
    endtask

    task automatic push_req(input bit we, input logic [23:0] adr, input logic [15:0] data, output bit accepted);
        @(negedge CLK);
        REQ_VALID = 1'b1;
        REQ_WE    = we;
        REQ_ADR   = adr;
        REQ_DATA  = data;
        accepted  = REQ_READY;
        @(posedge CLK);
        #1 REQ_VALID = 1'b0;
    endtask

    task automatic wait_strobes(input int n, input int budget);
        for (int i = 0; i < budget && strobes.size() < n; i++) @(posedge CLK);
    endtask

    task automatic wait_rsps(input int n, input int budget);
        for (int i = 0; i < budget && rsps.size() < n; i++) @(posedge CLK);
    endtask

    task automatic test_reset;
        #12;
        checks++;
        if ({REQ_READY, RE_IN, WE_IN, RSP_VALID} !== 4'b1000) begin
            errors++;
            $display("[TB] FAIL reset_flags: got %b expected 1000", {REQ_READY, RE_IN, WE_IN, RSP_VALID});
        end
        checks++;
        if ({ADR_IN, DIN, RSP_DATA} !== 56'h0) begin
            errors++;
            $display("[TB] FAIL reset_buses: got %h expected 0", {ADR_IN, DIN, RSP_DATA});
        end
        @(negedge CLK);
        RST = 1'b0;
        tick(2);
    endtask

    task automatic test_write;
        bit acc;
        strobes.delete();
        rsps.delete();
        lat = 3;
        push_req(1'b1, 24'h000123, 16'hBEEF, acc);
        wait_strobes(1, 20);
        tick(10);
        checks++;
        if (acc !== 1'b1) begin
            errors++;
            $display("[TB] FAIL write_accept: got %b expected 1", acc);
        end
        checks++;
        if (strobes.size() !== 1) begin
            errors++;
            $display("[TB] FAIL write_strobe_count: got %0d expected 1", strobes.size());
        end
        if (strobes.size() > 0) begin
            checks++;
            if ({strobes[0].we, strobes[0].adr, strobes[0].data} !== {1'b1, 24'h000123, 16'hBEEF}) begin
                errors++;
                $display("[TB] FAIL write_cmd: got we=%b adr=%h din=%h expected we=1 adr=000123 din=beef",
                         strobes[0].we, strobes[0].adr, strobes[0].data);
            end
        end
        checks++;
        if (rsps.size() !== 0) begin
            errors++;
            $display("[TB] FAIL write_no_rsp: got %0d responses expected 0", rsps.size());
        end
    endtask

    task automatic test_read;
        bit acc;
        strobes.delete();
        rsps.delete();
        lat = 5;
        dout_val = 16'h5A5A;
        push_req(1'b0, 24'h000040, 16'h0000, acc);
        wait_rsps(1, 40);
        tick(8);
        checks++;
        if (strobes.size() !== 1) begin
            errors++;
            $display("[TB] FAIL read_strobe_count: got %0d expected 1", strobes.size());
        end else begin
            checks++;
            if ({strobes[0].we, strobes[0].adr} !== {1'b0, 24'h000040}) begin
                errors++;
                $display("[TB] FAIL read_cmd: got we=%b adr=%h expected we=0 adr=000040",
                         strobes[0].we, strobes[0].adr);
            end
        end
        checks++;
        if (rsps.size() !== 1) begin
            errors++;
            $display("[TB] FAIL read_rsp_pulse: got %0d pulse cycles expected 1", rsps.size());
        end else begin
            checks++;
            if (rsps[0] !== 16'h5A5A) begin
                errors++;
                $display("[TB] FAIL read_rsp_data: got %h expected 5a5a", rsps[0]);
            end
        end
    endtask

    task automatic test_full;
        bit acc;
        logic [23:0] exp_adr;
        logic [15:0] exp_data;
        strobes.delete();
        rsps.delete();
        lat = 2;
        hold_rdy = 1'b1;
        tick(2);
        for (int i = 0; i < 8; i++) begin
            push_req(1'b1, 24'(24'h100 + i), 16'(16'h1000 + i), acc);
            checks++;
            if (acc !== 1'b1) begin
                errors++;
                $display("[TB] FAIL full_accept_%0d: got %b expected 1", i, acc);
            end
        end
        @(negedge CLK);
        checks++;
        if (REQ_READY !== 1'b0) begin
            errors++;
            $display("[TB] FAIL full_ready_low: got %b expected 0", REQ_READY);
        end
        push_req(1'b1, 24'h0001FF, 16'hDEAD, acc);
        checks++;
        if (acc !== 1'b0) begin
            errors++;
            $display("[TB] FAIL full_ninth_rejected: got %b expected 0", acc);
        end
        @(posedge CLK);
        #1 hold_rdy = 1'b0;
        wait_strobes(1, 10);
        #1;
        checks++;
        if (REQ_READY !== 1'b1) begin
            errors++;
            $display("[TB] FAIL full_ready_after_pop: got %b expected 1", REQ_READY);
        end
        wait_strobes(9, 200);
        tick(5);
        checks++;
        if (strobes.size() !== 8) begin
            errors++;
            $display("[TB] FAIL full_issue_count: got %0d expected 8", strobes.size());
        end
        for (int i = 0; i < 8 && i < strobes.size(); i++) begin
            exp_adr  = 24'(24'h100 + i);
            exp_data = 16'(16'h1000 + i);
            checks++;
            if ({strobes[i].we, strobes[i].adr, strobes[i].data} !== {1'b1, exp_adr, exp_data}) begin
                errors++;
                $display("[TB] FAIL full_order_%0d: got adr=%h din=%h expected adr=%h din=%h",
                         i, strobes[i].adr, strobes[i].data, exp_adr, exp_data);
            end
        end
    endtask

    task automatic test_alternating;
        bit acc;
        bit exp_we;
        strobes.delete();
        rsps.delete();
        viol = 0;
        rand_lat = 1'b1;
        fixed_dout = 1'b0;
        push_req(1'b1, 24'h000001, 16'hA001, acc);
        push_req(1'b0, 24'h000002, 16'h0000, acc);
        push_req(1'b1, 24'h000003, 16'hA003, acc);
        push_req(1'b0, 24'h000004, 16'h0000, acc);
        wait_strobes(4, 200);
        wait_rsps(2, 200);
        tick(5);
        rand_lat = 1'b0;
        fixed_dout = 1'b1;
        checks++;
        if (strobes.size() !== 4) begin
            errors++;
            $display("[TB] FAIL alt_strobe_count: got %0d expected 4", strobes.size());
        end
        for (int i = 0; i < 4 && i < strobes.size(); i++) begin
            exp_we = (i % 2 == 0);
            checks++;
            if ({strobes[i].we, strobes[i].adr} !== {exp_we, 24'(i + 1)}) begin
                errors++;
                $display("[TB] FAIL alt_order_%0d: got we=%b adr=%h expected we=%b adr=%h",
                         i, strobes[i].we, strobes[i].adr, exp_we, 24'(i + 1));
            end
        end
        checks++;
        if (rsps.size() !== 2) begin
            errors++;
            $display("[TB] FAIL alt_rsp_count: got %0d expected 2", rsps.size());
        end else begin
            checks++;
            if ({rsps[0], rsps[1]} !== {16'hC002, 16'hC004}) begin
                errors++;
                $display("[TB] FAIL alt_rsp_data: got %h %h expected c002 c004", rsps[0], rsps[1]);
            end
        end
        checks++;
        if (viol !== 0) begin
            errors++;
            $display("[TB] FAIL alt_strobe_rules: got %0d violations expected 0", viol);
        end
    endtask

    task automatic test_back_to_back;
        bit acc;
        logic [23:0] exp_adr;
        strobes.delete();
        rsps.delete();
        lat = 2;
        @(posedge CLK);
        #1 hold_rdy = 1'b1;
        for (int i = 0; i < 3; i++) push_req(1'b1, 24'(24'h200 + i), 16'(16'h2000 + i), acc);
        @(posedge CLK);
        #1 hold_rdy = 1'b0;
        push_req(1'b1, 24'h000203, 16'h2003, acc);
        checks++;
        if ({acc, dut.u_fifo.count} !== {1'b1, 4'd3}) begin
            errors++;
            $display("[TB] FAIL b2b_push_pop_count: got acc=%b count=%0d expected acc=1 count=3",
                     acc, dut.u_fifo.count);
        end
        for (int i = 4; i < 8; i++) begin
            push_req(1'b1, 24'(24'h200 + i), 16'(16'h2000 + i), acc);
            checks++;
            if (acc !== 1'b1) begin
                errors++;
                $display("[TB] FAIL b2b_accept_%0d: got %b expected 1", i, acc);
            end
        end
        wait_strobes(8, 200);
        tick(5);
        checks++;
        if (strobes.size() !== 8) begin
            errors++;
            $display("[TB] FAIL b2b_issue_count: got %0d expected 8", strobes.size());
        end
        for (int i = 0; i < 8 && i < strobes.size(); i++) begin
            exp_adr = 24'(24'h200 + i);
            checks++;
            if ({strobes[i].adr, strobes[i].data} !== {exp_adr, 16'(16'h2000 + i)}) begin
                errors++;
                $display("[TB] FAIL b2b_wrap_order_%0d: got adr=%h din=%h expected adr=%h din=%h",
                         i, strobes[i].adr, strobes[i].data, exp_adr, 16'(16'h2000 + i));
            end
        end
    endtask

    task automatic test_reset_midrun;
        bit acc;
        strobes.delete();
        rsps.delete();
        lat = 6;
        push_req(1'b0, 24'h000077, 16'h0000, acc);
        wait_strobes(1, 20);
        #1 hold_rdy = 1'b1;
        for (int i = 0; i < 8; i++) push_req(1'b1, 24'(24'h300 + i), 16'(16'h3000 + i), acc);
        checks++;
        if (REQ_READY !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midrun_full_before_reset: got %b expected 0", REQ_READY);
        end
        @(posedge CLK);
        #2 RST = 1'b1;
        #1;
        checks++;
        if ({REQ_READY, RE_IN, WE_IN, RSP_VALID} !== 4'b1000) begin
            errors++;
            $display("[TB] FAIL midrun_async_reset: got %b expected 1000", {REQ_READY, RE_IN, WE_IN, RSP_VALID});
        end
        hold_rdy = 1'b0;
        @(posedge CLK);
        #2 RST = 1'b0;
        tick(20);
        checks++;
        if ({strobes.size(), rsps.size()} !== {32'd1, 32'd0}) begin
            errors++;
            $display("[TB] FAIL midrun_discard: got strobes=%0d rsps=%0d expected strobes=1 rsps=0",
                     strobes.size(), rsps.size());
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_full();
        test_alternating();
        test_back_to_back();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
